register_file_mp: RTL
=====================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The parameter XLEN SHALL default to 32 and set the register width.
REQ-002 The parameter NREGS SHALL default to 32 and set the register count; it must be a power of two and at least 2.
REQ-003 The parameter NRD SHALL default to 2 and set the number of read ports, from 1 to 4.
REQ-004 The parameter ZERO_REG SHALL default to 1; when it is 1, register 0 reads as zero and ignores writes.
REQ-005 The derived width AW SHALL equal $clog2(NREGS).
REQ-006 clk  in  1  SHALL be the single clock; all state updates on the posedge.
REQ-007 rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-008 wr_ena  in  1  SHALL be the write enable.
REQ-009 wr_addr  in  AW  SHALL be the write address.
REQ-010 wr_data  in  XLEN  SHALL be the write data.
REQ-011 rd_addr[NRD]  in  AW each  SHALL be the read addresses.
REQ-012 rd_data[NRD]  out  XLEN each  SHALL be the read data.
REQ-013 rd_pending[NRD]  out  1 each  SHALL flag that the addressed register is reserved.
REQ-014 rsv_ena  in  1, together with rsv_addr  in  AW, SHALL be the scoreboard reservation request.
REQ-015 clr_req  in  1  SHALL be a single-cycle request to start a clear sweep.
REQ-016 clr_busy  out  1  SHALL be high while a clear sweep is in progress.

Function
REQ-017 Writes: on the posedge with wr_ena=1 and the FSM in CLR_IDLE, regs[wr_addr] SHALL be set to wr_data. When ZERO_REG=1 and wr_addr=0, the write SHALL be dropped.
REQ-018 Reads SHALL be combinational, with zero-cycle latency.
REQ-019 Read bypass: a read port SHALL return wr_data instead of the stored value when all of the following hold:
 - wr_ena=1;
 - wr_addr equals that port's rd_addr;
 - the FSM is in CLR_IDLE;
 - the address is not the dropped zero register.
REQ-020 When ZERO_REG=1, a read of address 0 SHALL return 0 and its rd_pending SHALL be 0.
REQ-021 Scoreboard set: with rsv_ena=1, pending[rsv_addr] SHALL be set at the posedge. Reservations of address 0 when ZERO_REG=1 are ignored.
REQ-022 Scoreboard clear: an accepted write SHALL clear pending[wr_addr] at the posedge. If rsv_ena and the write target the same address in the same cycle, the set SHALL win.
REQ-023 rd_pending[i] SHALL equal pending[rd_addr[i]], except that it SHALL be 0 when the read bypass of REQ-019 is active on that port.
REQ-024 The clear FSM SHALL have two states, CLR_IDLE and CLR_SWEEP.
REQ-025 In CLR_IDLE, clr_req=1 SHALL do three things at the same posedge:
 - move the FSM to CLR_SWEEP;
 - reset the sweep counter to 0;
 - clear all pending bits.
REQ-026 In CLR_SWEEP, each posedge SHALL zero regs[counter] and increment the counter. After zeroing NREGS-1, the FSM SHALL return to CLR_IDLE, so the sweep occupies exactly NREGS cycles.
REQ-027 clr_busy SHALL be 1 exactly while the FSM is in CLR_SWEEP.
REQ-028 During CLR_SWEEP, wr_ena, rsv_ena and clr_req SHALL be ignored. Reads SHALL return current stored contents with no bypass.
REQ-029 The sweep counter SHALL be AW bits wide, and its wrap from NREGS-1 SHALL coincide with the return to CLR_IDLE.

Reset
REQ-030 While rst_n=0, the block SHALL immediately (asynchronously) put itself in this state:
 - all registers 0 and all pending bits 0;
 - FSM in CLR_IDLE, sweep counter 0;
 - clr_busy 0, so rd_data and rd_pending read 0.
REQ-031 Reset asserted during CLR_SWEEP SHALL abort the sweep. After rst_n rises, no sweep SHALL resume.
REQ-032 The first posedge after rst_n deasserts SHALL accept writes, reservations and clr_req normally.

Structure
REQ-033 The package register_file_pkg SHALL hold three items:
 - the typedef enum clr_state_t {CLR_IDLE, CLR_SWEEP};
 - the constants DEFAULT_XLEN=32 and DEFAULT_NREGS=32;
 - the ABI name constants for x0..x31.
REQ-034 The sub-module rf_read_port SHALL implement one read port (mux, zero-register forcing, bypass and pending gating). It SHALL be instantiated NRD times through a generate loop.
REQ-035 Registers and pending bits SHALL be plain flip-flop arrays with async reset, with no inferred RAM macros.

Verification
REQ-036 Write/read: write 0xDEADBEEF to x5; the next cycle, read x5 on both ports and get 0xDEADBEEF. A write of 0x1234 to x0 reads back 0 when ZERO_REG=1.
REQ-037 Bypass: in the same cycle, write x7=0xA5A5A5A5 and read x7 on port 1. rd_data1 SHALL be 0xA5A5A5A5 in that cycle, with rd_pending1=0.
REQ-038 Scoreboard:
 - reserve x9, then read x9: rd_pending=1;
 - write x9=3 in a later cycle: pending clears;
 - simultaneous reserve and write on x9: pending stays 1.
REQ-039 Clear sweep:
 - load x1..x31 with nonzero values and pulse clr_req;
 - clr_busy SHALL be high for exactly 32 cycles, writes during the sweep SHALL be dropped, and afterwards all reads SHALL return 0.
REQ-040 Reset mid-sweep:
 - pulse rst_n low at sweep cycle 10;
 - immediately, all regs and pending bits are 0 and clr_busy is 0;
 - a write of x3=7 on the first cycle after release SHALL succeed.
REQ-041 Parameters: rerun REQ-036 and REQ-039 with XLEN=64, NREGS=16, NRD=3, ZERO_REG=0. x0 SHALL be writable, and the sweep SHALL last 16 cycles.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and constants for the multi-port register file with scoreboard and clear sweep.
package register_file_pkg;

    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;

    // RISC-V ABI register names
    localparam logic [4:0] ABI_ZERO = 5'd0,  ABI_RA  = 5'd1,  ABI_SP  = 5'd2,  ABI_GP  = 5'd3;
    localparam logic [4:0] ABI_TP   = 5'd4,  ABI_T0  = 5'd5,  ABI_T1  = 5'd6,  ABI_T2  = 5'd7;
    localparam logic [4:0] ABI_S0   = 5'd8,  ABI_S1  = 5'd9,  ABI_A0  = 5'd10, ABI_A1  = 5'd11;
    localparam logic [4:0] ABI_A2   = 5'd12, ABI_A3  = 5'd13, ABI_A4  = 5'd14, ABI_A5  = 5'd15;
    localparam logic [4:0] ABI_A6   = 5'd16, ABI_A7  = 5'd17, ABI_S2  = 5'd18, ABI_S3  = 5'd19;
    localparam logic [4:0] ABI_S4   = 5'd20, ABI_S5  = 5'd21, ABI_S6  = 5'd22, ABI_S7  = 5'd23;
    localparam logic [4:0] ABI_S8   = 5'd24, ABI_S9  = 5'd25, ABI_S10 = 5'd26, ABI_S11 = 5'd27;
    localparam logic [4:0] ABI_T3   = 5'd28, ABI_T4  = 5'd29, ABI_T5  = 5'd30, ABI_T6  = 5'd31;

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: write, read, reservation and clear-sweep signals.
interface register_file_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic            wr_ena;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [AW-1:0]   rd_addr    [NRD];
    logic [XLEN-1:0] rd_data    [NRD];
    logic            rd_pending [NRD];
    logic            rsv_ena;
    logic [AW-1:0]   rsv_addr;
    logic            clr_req;
    logic            clr_busy;

    modport master (
        output wr_ena, wr_addr, wr_data, rd_addr, rsv_ena, rsv_addr, clr_req,
        input  rd_data, rd_pending, clr_busy
    );

    modport slave (
        input  wr_ena, wr_addr, wr_data, rd_addr, rsv_ena, rsv_addr, clr_req,
        output rd_data, rd_pending, clr_busy
    );
endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: register mux, zero-register forcing, write bypass, pending gating.
module rf_read_port #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  logic [NREGS-1:0]           pending,
    input  logic [AW-1:0]              rd_addr,
    input  logic                       wr_acc,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    output logic [XLEN-1:0]            rd_data,
    output logic                       rd_pending
);

    // wr_acc already excludes sweeps and dropped zero-register writes, so it alone qualifies bypass
    always_comb begin
        rd_data    = regs[rd_addr];
        rd_pending = pending[rd_addr];
        if ((ZERO_REG == 1'b1) && (rd_addr == {AW{1'b0}})) begin
            rd_data    = {XLEN{1'b0}};
            rd_pending = 1'b0;
        end else if (wr_acc && (wr_addr == rd_addr)) begin
            rd_data    = wr_data;
            rd_pending = 1'b0;
        end else begin
            rd_data    = regs[rd_addr];
            rd_pending = pending[rd_addr];
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with reservation scoreboard and a one-register-per-cycle clear sweep.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    register_file_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    clr_state_t                 state_r;
    clr_state_t                 state_nxt_s;
    logic [AW-1:0]              cnt_r;
    logic [NREGS-1:0][XLEN-1:0] regs_r;
    logic [NREGS-1:0]           pending_r;
    logic                       idle_s;
    logic                       sweep_s;
    logic                       clr_start_s;
    logic                       sweep_last_s;
    logic                       wr_acc_s;
    logic                       rsv_acc_s;

    // Clear FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= CLR_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Clear FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            CLR_IDLE:  if (bus.clr_req) state_nxt_s = CLR_SWEEP; else state_nxt_s = CLR_IDLE;
            CLR_SWEEP: if (sweep_last_s) state_nxt_s = CLR_IDLE; else state_nxt_s = CLR_SWEEP;
            default:   state_nxt_s = CLR_IDLE;
        endcase
    end

    // Clear FSM outputs and write/reservation qualification; rst_n gating keeps bypass quiet in reset
    always_comb begin
        idle_s  = 1'b0;
        sweep_s = 1'b0;
        case (state_r)
            CLR_IDLE:  idle_s  = 1'b1;
            CLR_SWEEP: sweep_s = 1'b1;
            default:   idle_s  = 1'b0;
        endcase
        clr_start_s  = idle_s && bus.clr_req;
        sweep_last_s = sweep_s && (cnt_r == AW'(NREGS - 1));
        wr_acc_s     = rst_n && idle_s && bus.wr_ena &&
                       !((ZERO_REG == 1'b1) && (bus.wr_addr == {AW{1'b0}}));
        rsv_acc_s    = rst_n && idle_s && bus.rsv_ena &&
                       !((ZERO_REG == 1'b1) && (bus.rsv_addr == {AW{1'b0}}));
    end

    // Sweep counter: wraps from NREGS-1 to 0 on the same edge the FSM returns to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {AW{1'b0}};
        end else if (clr_start_s) begin
            cnt_r <= {AW{1'b0}};
        end else if (sweep_s) begin
            cnt_r <= cnt_r + AW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Register array: sweep zeroing or accepted write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_r <= {(NREGS * XLEN){1'b0}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (sweep_s && (cnt_r == AW'(i))) begin
                    regs_r[i] <= {XLEN{1'b0}};
                end else if (wr_acc_s && (bus.wr_addr == AW'(i))) begin
                    regs_r[i] <= bus.wr_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Scoreboard: clear-all on sweep start, reservation set wins over write clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {NREGS{1'b0}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (clr_start_s) begin
                    pending_r[i] <= 1'b0;
                end else if (rsv_acc_s && (bus.rsv_addr == AW'(i))) begin
                    pending_r[i] <= 1'b1;
                end else if (wr_acc_s && (bus.wr_addr == AW'(i))) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        rf_read_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .ZERO_REG (ZERO_REG),
            .AW       (AW)
        ) u_rd_port (
            .regs       (regs_r),
            .pending    (pending_r),
            .rd_addr    (bus.rd_addr[g]),
            .wr_acc     (wr_acc_s),
            .wr_addr    (bus.wr_addr),
            .wr_data    (bus.wr_data),
            .rd_data    (bus.rd_data[g]),
            .rd_pending (bus.rd_pending[g])
        );
    end

    assign bus.clr_busy = sweep_s;

endmodule
